// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester handshake and SRAM pin bundle for sram_arbiter
interface sram_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int AW     = 19,
  parameter int DW     = 8
);
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    wr;
  logic [NUM_CH*AW-1:0] addr;
  logic [NUM_CH*DW-1:0] wdata;
  logic [NUM_CH-1:0]    grant;
  logic [NUM_CH-1:0]    done;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        sram_a;
  logic [DW-1:0]        sram_dout;
  logic                 sram_oe;
  logic [DW-1:0]        sram_din;
  logic                 n_vrd;
  logic                 n_vwr;
  logic                 busy;

  // arbiter side
  modport slave (
    input  req, wr, addr, wdata, sram_din,
    output grant, done, rdata, sram_a, sram_dout, sram_oe, n_vrd, n_vwr, busy
  );

  // requesters plus SRAM model side
  modport master (
    output req, wr, addr, wdata, sram_din,
    input  grant, done, rdata, sram_a, sram_dout, sram_oe, n_vrd, n_vwr, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - N-channel req/grant/done arbiter for the shared video/CPU SRAM
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int AW            = 19,
  parameter int DW            = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int PRIO0         = 1,
  parameter int MAX_WAIT      = 4
) (
  input  logic         clk28,
  input  logic         rst_n,
  sram_arbiter_if.slave bus
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_wr;
  logic [PW-1:0]     r_ptr;
  logic [NUM_CH-1:0] r_grant;
  logic [NUM_CH-1:0] r_done;
  logic [DW-1:0]     r_rdata;
  logic [AW-1:0]     r_sram_a;
  logic [DW-1:0]     r_sram_dout;
  logic              r_oe;
  logic              r_n_vrd;
  logic              r_n_vwr;

  logic [PW-1:0]     w_rr_idx;
  logic [PW-1:0]     w_win;
  logic              w_upd_ptr;
  logic [PW-1:0]     w_ptr_next;
  logic [NUM_CH-1:0] w_win_oh;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_wait [NUM_CH];
`endif

  // circular search from the pointer; channel 0 is skipped when it has its own priority path
  always_comb begin
    logic [PW-1:0] v_idx;
    logic          v_found;
    w_rr_idx = '0;
    v_found  = 1'b0;
    v_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v_idx = PW'((int'(r_ptr) + k) % NUM_CH);
      if (!v_found && bus.req[v_idx] && !(PRIO0 != 0 && v_idx == '0)) begin
        v_found  = 1'b1;
        w_rr_idx = v_idx;
      end
    end
  end

  // final winner: starved channel, then channel 0 priority, then round-robin
  always_comb begin
    w_win     = w_rr_idx;
    w_upd_ptr = 1'b1;
    if (PRIO0 != 0 && bus.req[0]) begin
      w_win     = '0;
      w_upd_ptr = 1'b0;
    end
`ifdef ARB_STARVE_GUARD_EN
    // descending scan so the lowest-numbered starved channel ends up selected
    for (int c = NUM_CH - 1; c >= 1; c--) begin
      if (bus.req[c] && r_wait[c] >= 4'(MAX_WAIT)) begin
        w_win     = PW'(c);
        w_upd_ptr = 1'b1;
      end
    end
`endif
    if (int'(w_win) == NUM_CH - 1) begin
      w_ptr_next = (PRIO0 != 0) ? PW'(1) : '0;
    end else begin
      w_ptr_next = w_win + 1'b1;
    end
    w_win_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;
  end

  // access sequencer: IDLE arbitrates, ACCESS holds a strobe, DONE pulses done and holds write data
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_ptr       <= PW'(1);
      r_grant     <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_sram_a    <= '0;
      r_sram_dout <= '0;
      r_oe        <= 1'b0;
      r_n_vrd     <= 1'b1;
      r_n_vwr     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (|bus.req) begin
            r_state     <= S_ACCESS;
            r_cnt       <= 4'(ACCESS_CYCLES - 1);
            r_grant     <= w_win_oh;
            r_sram_a    <= bus.addr[w_win*AW +: AW];
            r_sram_dout <= bus.wdata[w_win*DW +: DW];
            r_wr        <= bus.wr[w_win];
            if (bus.wr[w_win]) begin
              r_n_vwr <= 1'b0;
              r_oe    <= 1'b1;
            end else begin
              r_n_vrd <= 1'b0;
            end
            if (w_upd_ptr) begin
              r_ptr <= w_ptr_next;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_wr) begin
              r_rdata <= bus.sram_din;
            end
            r_n_vrd <= 1'b1;
            r_n_vwr <= 1'b1;
            r_done  <= r_grant;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_grant <= '0;
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // count arbitrations lost while requesting; the winner starts over
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_wait[c] <= '0;
    end else if (r_state == S_IDLE && |bus.req) begin
      for (int c = 1; c < NUM_CH; c++) begin
        if (PW'(c) == w_win) begin
          r_wait[c] <= '0;
        end else if (bus.req[c] && r_wait[c] != 4'hF) begin
          r_wait[c] <= r_wait[c] + 4'd1;
        end
      end
    end
  end
`endif

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.sram_a    = r_sram_a;
  assign bus.sram_dout = r_sram_dout;
  assign bus.sram_oe   = r_oe;
  assign bus.n_vrd     = r_n_vrd;
  assign bus.n_vwr     = r_n_vwr;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  localparam int NUM_CH = 4;
  localparam int AW     = 19;
  localparam int DW     = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic overlap_seen = 1'b0;
  logic addr_moved   = 1'b0;
  logic prev_strobe  = 1'b0;
  logic [AW-1:0] prev_a = '0;
  logic [3:0] exp_rr [4];
  logic [3:0] exp_p0 [5];

  always #5 clk = ~clk;

  sram_arbiter_if #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW)) bus ();

  sram_arbiter #(
    .NUM_CH(NUM_CH), .AW(AW), .DW(DW),
    .ACCESS_CYCLES(2), .PRIO0(1), .MAX_WAIT(4)
  ) dut (
    .clk28(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // strobe overlap and address stability watcher
  always @(negedge clk) begin
    if (!bus.n_vrd && !bus.n_vwr) overlap_seen = 1'b1;
    if ((!bus.n_vrd || !bus.n_vwr) && prev_strobe && bus.sram_a !== prev_a) addr_moved = 1'b1;
    prev_strobe = !bus.n_vrd || !bus.n_vwr;
    prev_a      = bus.sram_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
`ifdef ARB_STARVE_GUARD_EN
    exp_p0 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    exp_p0 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.wr       = '0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.sram_din = '0;
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_n_vrd", 32'(bus.n_vrd), 32'h1);
    chk("rst_n_vwr", 32'(bus.n_vwr), 32'h1);
    chk("rst_oe", 32'(bus.sram_oe), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_sram_a", 32'(bus.sram_a), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // read by channel 1
    bus.req = 4'b0010;
    bus.addr[1*AW +: AW] = 19'h1C123;
    bus.sram_din = 8'h5A;
    tick();
    chk("rd_n_vrd_c1", 32'(bus.n_vrd), 32'h0);
    chk("rd_grant", 32'(bus.grant), 32'h2);
    chk("rd_sram_a", 32'(bus.sram_a), 32'h1C123);
    chk("rd_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("rd_n_vrd_c2", 32'(bus.n_vrd), 32'h0);
    chk("rd_done_early", 32'(bus.done), 32'h0);
    tick();
    chk("rd_n_vrd_c3", 32'(bus.n_vrd), 32'h1);
    chk("rd_done", 32'(bus.done), 32'h2);
    chk("rd_rdata", 32'(bus.rdata), 32'h5A);
    bus.req = '0;
    bus.sram_din = 8'h00;
    tick();
    chk("rd_done_clr", 32'(bus.done), 32'h0);
    chk("rd_grant_clr", 32'(bus.grant), 32'h0);
    chk("rd_idle", 32'(bus.busy), 32'h0);

    // write by channel 2
    bus.req = 4'b0100;
    bus.wr  = 4'b0100;
    bus.addr[2*AW +: AW]  = 19'h00010;
    bus.wdata[2*DW +: DW] = 8'hA5;
    tick();
    chk("wr_n_vwr_c1", 32'(bus.n_vwr), 32'h0);
    chk("wr_n_vrd_c1", 32'(bus.n_vrd), 32'h1);
    chk("wr_oe_c1", 32'(bus.sram_oe), 32'h1);
    chk("wr_dout", 32'(bus.sram_dout), 32'hA5);
    chk("wr_sram_a", 32'(bus.sram_a), 32'h10);
    tick();
    chk("wr_n_vwr_c2", 32'(bus.n_vwr), 32'h0);
    chk("wr_oe_c2", 32'(bus.sram_oe), 32'h1);
    tick();
    chk("wr_n_vwr_c3", 32'(bus.n_vwr), 32'h1);
    chk("wr_oe_c3", 32'(bus.sram_oe), 32'h1);
    chk("wr_done", 32'(bus.done), 32'h4);
    chk("wr_rdata_held", 32'(bus.rdata), 32'h5A);
    bus.req = '0;
    bus.wr  = '0;
    tick();
    chk("wr_oe_off", 32'(bus.sram_oe), 32'h0);

    // round-robin among channels 1..3 from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1110;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("rr_grant_%0d", s), 32'(bus.grant), 32'(exp_rr[s]));
      tick();
      tick();
      chk($sformatf("rr_done_%0d", s), 32'(bus.done), 32'(exp_rr[s]));
      tick();
      chk($sformatf("rr_gap_%0d", s), 32'(bus.grant), 32'h0);
    end
    bus.req = '0;
    tick();

    // all channels requesting: channel 0 priority
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("p0_grant_%0d", s), 32'(bus.grant), 32'(exp_p0[s]));
      tick();
      tick();
      tick();
    end
    bus.req = '0;
    tick();

    // reset in the first ACCESS cycle of a write
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b0100;
    bus.wr  = 4'b0100;
    tick();
    chk("ab_n_vwr_low", 32'(bus.n_vwr), 32'h0);
    rst_n = 1'b0;
    tick();
    chk("ab_n_vwr", 32'(bus.n_vwr), 32'h1);
    chk("ab_oe", 32'(bus.sram_oe), 32'h0);
    chk("ab_grant", 32'(bus.grant), 32'h0);
    chk("ab_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    bus.req = 4'b1100;
    bus.wr  = 4'b0000;
    tick();
    chk("ab_rearb_ptr1", 32'(bus.grant), 32'h4);
    bus.req = '0;
    tick();
    tick();
    chk("ab_done_after", 32'(bus.done), 32'h4);
    tick();

    // request dropped and address changed mid-access
    bus.req = 4'b0010;
    bus.addr[1*AW +: AW] = 19'h3ABCD;
    bus.sram_din = 8'h77;
    tick();
    chk("dr_sram_a0", 32'(bus.sram_a), 32'h3ABCD);
    bus.req = '0;
    bus.addr[1*AW +: AW] = 19'h00001;
    tick();
    chk("dr_sram_a1", 32'(bus.sram_a), 32'h3ABCD);
    chk("dr_n_vrd", 32'(bus.n_vrd), 32'h0);
    tick();
    chk("dr_done", 32'(bus.done), 32'h2);
    chk("dr_rdata", 32'(bus.rdata), 32'h77);
    chk("dr_sram_a2", 32'(bus.sram_a), 32'h3ABCD);
    tick();
    tick();
    chk("dr_no_rearb", 32'(bus.grant), 32'h0);

    chk("no_strobe_overlap", 32'(overlap_seen), 32'h0);
    chk("addr_stable", 32'(addr_moved), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
